// File: rtl/switch_cfg_pkg.sv
// -----------------------------------------------------------------------------
// switch_cfg_pkg
//   Shared configuration for the N-port packet switch: default geometry, the
//   pointer-width helper used to size port indices, and the packet types for
//   the default geometry. Modules whose widths depend on their own parameters
//   size their local types from those parameters and use ptr_width() for
//   index widths.
// -----------------------------------------------------------------------------
package switch_cfg_pkg;

  localparam int MAX_PORTS      = 8;
  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Width of a port index; never below 1 so that a 2-port switch still has a
  // real pointer bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int PTR_W = ptr_width(DEF_NUM_PORTS);

  typedef logic [PTR_W-1:0]         port_idx_t;
  typedef logic [DEF_NUM_PORTS-1:0] port_mask_t;

  typedef struct packed {
    port_mask_t              target;
    logic [DEF_DATA_W-1:0]   data;
  } pkt_t;

endpackage

// File: rtl/switch_rr_arbiter.sv
// -----------------------------------------------------------------------------
// switch_rr_arbiter
//   Combinational round-robin arbiter for one switch output. Grants the first
//   requester at or after ptr, wrapping around. The pointer register itself is
//   owned by the parent so that all outputs update in one place.
// Ports
//   req  in   [N]           per-input request
//   ptr  in   [ptr_width]   index with highest priority this cycle
//   gnt  out  [N]           one-hot grant, all-zero when nothing requests
// -----------------------------------------------------------------------------
module switch_rr_arbiter
  import switch_cfg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            req,
  input  logic [ptr_width(N)-1:0] ptr,
  output logic [N-1:0]            gnt
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] sel;

  // Requests at or above ptr take priority; if none exist the search wraps to
  // the full request vector. Either way the lowest set bit wins.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      hi_mask[k] = (k >= int'(ptr));
    end
    hi_req = req & hi_mask;
    sel    = (hi_req != '0) ? hi_req : req;
    gnt    = sel & (~sel + {{(N-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/switch_nport_fabric.sv
// -----------------------------------------------------------------------------
// switch_nport_fabric
//   Parametrised N-port single-beat packet switch. Each input has a FIFO; each
//   output runs a round-robin arbiter over the head-of-line packets that still
//   target it. Multicast heads are served output by output and retire once
//   every target has been served.
//
// Optional feature: define SWITCH_STATS_EN to add per-input saturating drop
//   counters and the drop_cnt port.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   valid_in    in   [NUM_PORTS]              input beat valid
//   target_in   in   [NUM_PORTS][NUM_PORTS]   destination mask per input
//   data_in     in   [NUM_PORTS][DATA_W]      payload per input
//   in_ready    out  [NUM_PORTS]              input FIFO not full
//   valid_out   out  [NUM_PORTS]              one-cycle pulse per delivered beat
//   source_out  out  [NUM_PORTS][clog2]       originating input of the beat
//   data_out    out  [NUM_PORTS][DATA_W]      delivered payload
//   drop_cnt    out  [NUM_PORTS][16]          refused beats (SWITCH_STATS_EN)
// -----------------------------------------------------------------------------
module switch_nport_fabric
  import switch_cfg_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_PORTS-1:0]                         valid_in,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]          target_in,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]             data_in,
  output logic [NUM_PORTS-1:0]                         in_ready,
  output logic [NUM_PORTS-1:0]                         valid_out,
  output logic [NUM_PORTS-1:0][$clog2(NUM_PORTS)-1:0]  source_out,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]             data_out
`ifdef SWITCH_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]                   drop_cnt
`endif
);

  localparam int PW = ptr_width(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [PW-1:0]        idx_t;
  typedef logic [NUM_PORTS-1:0] mask_t;

  typedef struct packed {
    mask_t             target;
    logic [DATA_W-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t      mem [NUM_PORTS][FIFO_DEPTH];
  logic [AW:0] wr_ptr_q [NUM_PORTS];
  logic [AW:0] wr_ptr_d [NUM_PORTS];
  logic [AW:0] rd_ptr_q [NUM_PORTS];
  logic [AW:0] rd_ptr_d [NUM_PORTS];
  mask_t       served_q [NUM_PORTS];
  mask_t       served_d [NUM_PORTS];
  idx_t        rr_q     [NUM_PORTS];
  idx_t        rr_d     [NUM_PORTS];

  logic [NUM_PORTS-1:0]             valid_out_q,  valid_out_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_out_q,   data_out_d;
  logic [NUM_PORTS-1:0][PW-1:0]     source_out_q, source_out_d;

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0]                empty, full, push, pop;
  entry_t                              head      [NUM_PORTS];
  mask_t                               store_tgt [NUM_PORTS];
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;     // req[output][input]
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;     // gnt[output][input]
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_to;  // gnt_to[input][output]

  // FIFO status, ingress filtering and head-of-line requests.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      // Same slot index with opposite wrap bits means the ring is full.
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      head[i]  = mem[i][rd_ptr_q[i][AW-1:0]];
      // Loopback is never delivered; a beat left with no target is discarded.
      store_tgt[i] = target_in[i] & ~(mask_t'(1) << i);
      push[i]      = valid_in[i] && !full[i] && (store_tgt[i] != '0);
      for (int j = 0; j < NUM_PORTS; j++) begin
        req[j][i] = !empty[i] && head[i].target[j] && !served_q[i][j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One arbiter per output
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    switch_rr_arbiter #(
      .N (NUM_PORTS)
    ) u_arb (
      .req (req[j]),
      .ptr (rr_q[j]),
      .gnt (gnt[j])
    );
  end

  // Grant decode: egress registers, pointer advance and per-input grant view.
  always_comb begin
    // NOTE: every variable gets a default before the loops so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    gnt_to       = '0;
    valid_out_d  = '0;
    data_out_d   = data_out_q;
    source_out_d = source_out_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      rr_d[j] = rr_q[j];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[j][i]) begin
          gnt_to[i][j]    = 1'b1;
          valid_out_d[j]  = 1'b1;
          data_out_d[j]   = head[i].data;
          source_out_d[j] = idx_t'(i);
          rr_d[j]         = (i == NUM_PORTS - 1) ? '0 : idx_t'(i + 1);
        end
      end
    end
  end

  // Retire: a head pops once the grants so far plus this cycle's cover its
  // whole target mask; otherwise the new grants are remembered so the head
  // does not request those outputs again.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      pop[i]      = 1'b0;
      served_d[i] = served_q[i];
      if (!empty[i]) begin
        if ((served_q[i] | gnt_to[i][NUM_PORTS-1:0]) == head[i].target) begin
          pop[i]      = 1'b1;
          served_d[i] = '0;
        end else begin
          served_d[i] = served_q[i] | gnt_to[i][NUM_PORTS-1:0];
        end
      end
      wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push[i]};
      rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop[i]};
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        served_q[i] <= '0;
        rr_q[i]     <= '0;
      end
      valid_out_q  <= '0;
      data_out_q   <= '0;
      source_out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        served_q[i] <= served_d[i];
        rr_q[i]     <= rr_d[i];
      end
      valid_out_q  <= valid_out_d;
      data_out_q   <= data_out_d;
      source_out_q <= source_out_d;
    end
  end

  // NOTE: the FIFO storage has no reset; resetting the pointers already makes
  // every slot unreachable, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr_q[i][AW-1:0]] <= {store_tgt[i], data_in[i]};
      end
    end
  end

`ifdef SWITCH_STATS_EN
  logic [NUM_PORTS-1:0][15:0] drop_cnt_q, drop_cnt_d;

  // Counts every beat offered while the FIFO is full, saturating at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      drop_cnt_d[i] = drop_cnt_q[i];
      if (valid_in[i] && full[i] && (drop_cnt_q[i] != 16'hFFFF)) begin
        drop_cnt_d[i] = drop_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign in_ready   = ~full;
  assign valid_out  = valid_out_q;
  assign data_out   = data_out_q;
  assign source_out = source_out_q;

endmodule

// File: tb/tb_switch_nport_fabric.sv
// -----------------------------------------------------------------------------
// tb_switch_nport_fabric
//   Self-checking bench for switch_nport_fabric (4 ports, 8-bit data, depth 4).
//   A queue-based reference model predicts every output each cycle; directed
//   scenarios add literal expectations. Build with SWITCH_STATS_EN to also
//   check the drop counters.
// -----------------------------------------------------------------------------
module tb_switch_nport_fabric;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic                     clk;
  logic                     rst_n;
  logic [NP-1:0]            valid_in;
  logic [NP-1:0][NP-1:0]    target_in;
  logic [NP-1:0][DW-1:0]    data_in;
  logic [NP-1:0]            in_ready;
  logic [NP-1:0]            valid_out;
  logic [NP-1:0][1:0]       source_out;
  logic [NP-1:0][DW-1:0]    data_out;
`ifdef SWITCH_STATS_EN
  logic [NP-1:0][15:0]      drop_cnt;
`endif

  switch_nport_fabric #(
    .NUM_PORTS  (NP),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .target_in  (target_in),
    .data_in    (data_in),
    .in_ready   (in_ready),
    .valid_out  (valid_out),
    .source_out (source_out),
    .data_out   (data_out)
`ifdef SWITCH_STATS_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_mis = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-input queues, served masks and rr pointers
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [NP-1:0] tgt;
    logic [DW-1:0] data;
  } ent_t;

  ent_t                  mq [NP][$];
  logic [NP-1:0]         m_served [NP];
  int                    m_rr [NP];
  int unsigned           m_drop [NP];
  logic [NP-1:0]         exp_valid;
  logic [NP-1:0][DW-1:0] exp_data;
  logic [NP-1:0][1:0]    exp_src;
  logic [NP-1:0]         exp_ready;

  always @(posedge clk or negedge rst_n) begin
    int            g  [NP];
    int            sz [NP];
    logic [NP-1:0] gi [NP];
    logic [NP-1:0] m;
    int            ii;
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        mq[i].delete();
        m_served[i] = '0;
        m_rr[i]     = 0;
        m_drop[i]   = 0;
      end
      exp_valid = '0;
      exp_data  = '0;
      exp_src   = '0;
      exp_ready = '1;
    end else begin
      for (int i = 0; i < NP; i++) begin
        sz[i] = mq[i].size();
        gi[i] = '0;
      end
      // Each output picks the first eligible head at or after its pointer.
      for (int j = 0; j < NP; j++) begin
        g[j] = -1;
        for (int k = 0; k < NP; k++) begin
          ii = (m_rr[j] + k) % NP;
          if (g[j] < 0 && sz[ii] > 0 && mq[ii][0].tgt[j] && !m_served[ii][j]) g[j] = ii;
        end
      end
      for (int j = 0; j < NP; j++) begin
        if (g[j] >= 0) begin
          exp_valid[j] = 1'b1;
          exp_data[j]  = mq[g[j]][0].data;
          exp_src[j]   = 2'(g[j]);
          m_rr[j]      = (g[j] + 1) % NP;
          gi[g[j]][j]  = 1'b1;
        end else begin
          exp_valid[j] = 1'b0;
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (sz[i] > 0) begin
          if ((m_served[i] | gi[i]) == mq[i][0].tgt) begin
            void'(mq[i].pop_front());
            m_served[i] = '0;
          end else begin
            m_served[i] = m_served[i] | gi[i];
          end
        end
      end
      // Acceptance depends on the occupancy before this edge's pop.
      for (int i = 0; i < NP; i++) begin
        if (valid_in[i]) begin
          if (sz[i] < DEPTH) begin
            m    = target_in[i];
            m[i] = 1'b0;
            if (m != '0) mq[i].push_back('{tgt: m, data: data_in[i]});
          end else if (m_drop[i] < 32'hFFFF) begin
            m_drop[i]++;
          end
        end
      end
      for (int i = 0; i < NP; i++) exp_ready[i] = (mq[i].size() < DEPTH);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_out", 64'(valid_out), 64'(exp_valid));
      check("data_out", 64'(data_out), 64'(exp_data));
      check("source_out", 64'(source_out), 64'(exp_src));
      check("in_ready", 64'(in_ready), 64'(exp_ready));
`ifdef SWITCH_STATS_EN
      for (int i = 0; i < NP; i++) check("drop_cnt", 64'(drop_cnt[i]), 64'(m_drop[i]));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [NP-1:0] v, input logic [NP-1:0][NP-1:0] t,
                       input logic [NP-1:0][DW-1:0] d);
    @(posedge clk);
    #1;
    valid_in  = v;
    target_in = t;
    data_in   = d;
  endtask

  // Presents one beat set for exactly one edge and returns just after it.
  task automatic send(input logic [NP-1:0] v, input logic [NP-1:0][NP-1:0] t,
                      input logic [NP-1:0][DW-1:0] d);
    drive(v, t, d);
    drive('0, '0, '0);
  endtask

  logic [1:0] saw_block;

  initial begin
    logic [NP-1:0]         rv;
    logic [NP-1:0][NP-1:0] rt;
    logic [NP-1:0][DW-1:0] rd;
    logic [NP-1:0]         dens;

    rst_n     = 1'b0;
    valid_in  = '0;
    target_in = '0;
    data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_out", 64'(valid_out), 64'h0);
    check("reset_in_ready", 64'(in_ready), 64'hF);
    check("reset_data_out", 64'(data_out), 64'h0);
    check("reset_source_out", 64'(source_out), 64'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: unicast P3 -> port0
    send(4'b1000, {4'b0001, 4'h0, 4'h0, 4'h0}, {8'h33, 8'h00, 8'h00, 8'h00});
    @(negedge clk);
    check("uni_before", 64'(valid_out), 64'h0);
    @(negedge clk);
    check("uni_valid", 64'(valid_out), 64'b0001);
    check("uni_data", 64'(data_out[0]), 64'h33);
    check("uni_src", 64'(source_out[0]), 64'd3);
    @(negedge clk);
    check("uni_pulse", 64'(valid_out), 64'h0);

    // 2: multicast clash P0 and P1 -> ports 2,3
    send(4'b0011, {4'h0, 4'h0, 4'b1100, 4'b1100}, {8'h00, 8'h00, 8'hB0, 8'hA0});
    @(negedge clk);
    @(negedge clk);
    check("mc_first_valid", 64'(valid_out), 64'b1100);
    check("mc_first_data", 64'({data_out[3], data_out[2]}), 64'hA0A0);
    check("mc_first_src", 64'({source_out[3], source_out[2]}), 64'h0);
    @(negedge clk);
    check("mc_second_valid", 64'(valid_out), 64'b1100);
    check("mc_second_data", 64'({data_out[3], data_out[2]}), 64'hB0B0);
    check("mc_second_src", 64'({source_out[3], source_out[2]}), 64'b0101);

    // 3: broadcast from P2 plus unicast P3 -> port0
    send(4'b1100, {4'b0001, 4'b1111, 4'h0, 4'h0}, {8'h33, 8'hFF, 8'h00, 8'h00});
    @(negedge clk);
    @(negedge clk);
    check("bc_valid", 64'(valid_out), 64'b1011);
    check("bc_data", 64'({data_out[3], data_out[1], data_out[0]}), 64'hFFFFFF);
    check("bc_src0", 64'(source_out[0]), 64'd2);
    @(negedge clk);
    check("bc_uni_valid", 64'(valid_out), 64'b0001);
    check("bc_uni_data", 64'(data_out[0]), 64'h33);
    check("bc_uni_src", 64'(source_out[0]), 64'd3);

    // 5: self and zero targets are discarded
    send(4'b0010, {4'h0, 4'h0, 4'b0010, 4'h0}, {8'h00, 8'h00, 8'h55, 8'h00});
    send(4'b0010, '0, {8'h00, 8'h00, 8'h56, 8'h00});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("self_zero_quiet", 64'(valid_out), 64'h0);
    end
`ifdef SWITCH_STATS_EN
    check("self_zero_drop", 64'(drop_cnt[1]), 64'h0);
`endif

    // 4: saturation, P0 and P1 stream into port2
    saw_block = '0;
    for (int c = 0; c < 12; c++) begin
      drive(4'b0011, {4'h0, 4'h0, 4'b0100, 4'b0100}, {8'h00, 8'h00, 8'(8'h80 + c), 8'(c)});
      @(negedge clk);
      if (!in_ready[0]) saw_block[0] = 1'b1;
      if (!in_ready[1]) saw_block[1] = 1'b1;
    end
    drive('0, '0, '0);
    repeat (20) @(negedge clk);
    check("sat_backpressure", 64'(saw_block), 64'b11);
    check("sat_drained_ready", 64'(in_ready), 64'hF);

    // Randomised traffic with varying density
    for (int c = 0; c < 480; c++) begin
      dens = (c < 160) ? 4'hF : (c < 320) ? 4'(($urandom & 4'hF) | 4'h3) : 4'(c[5:2]);
      rv   = 4'($urandom) & dens;
      for (int i = 0; i < NP; i++) begin
        rt[i] = 4'($urandom);
        rd[i] = 8'($urandom);
      end
      drive(rv, rt, rd);
    end
    drive('0, '0, '0);
    repeat (40) @(negedge clk);
    check("rand_drained_ready", 64'(in_ready), 64'hF);

    // 6: reset in the middle of traffic
    for (int c = 0; c < 6; c++) begin
      drive(4'b1110, {4'b0001, 4'b0001, 4'b0001, 4'h0},
            {8'($urandom), 8'($urandom), 8'($urandom), 8'h00});
    end
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    valid_in  = '0;
    target_in = '0;
    data_in   = '0;
    #1;
    check("midrst_valid_out", 64'(valid_out), 64'h0);
    check("midrst_in_ready", 64'(in_ready), 64'hF);
    check("midrst_data_out", 64'(data_out), 64'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("postrst_quiet", 64'(valid_out), 64'h0);
    end
    send(4'b1100, {4'b0001, 4'b0001, 4'h0, 4'h0}, {8'h3C, 8'h2C, 8'h00, 8'h00});
    @(negedge clk);
    @(negedge clk);
    check("postrst_first_src", 64'(source_out[0]), 64'd2);
    check("postrst_first_data", 64'(data_out[0]), 64'h2C);
    @(negedge clk);
    check("postrst_second_src", 64'(source_out[0]), 64'd3);
    check("postrst_second_data", 64'(data_out[0]), 64'h3C);
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
